// File: rtl/hazard_frame_sequencer.sv
// Hazard frame sequencer: collects hazard bounding boxes for one frame, rasterises
// them into a ROWS x COLS occupancy mask (one stored box per cycle), then hands the
// mask to the spike-input stage as two 16-bit halves over valid/ready.
module hazard_frame_sequencer #(
    parameter int MAX_HAZ   = 16,
    parameter int CW        = 5,
    parameter int ROWS      = 4,
    parameter int COLS      = 8,
    parameter int ROW_SHIFT = 1,
    parameter int COL_SHIFT = 2,
    localparam int CNTW     = $clog2(MAX_HAZ) + 1,
    localparam int IW       = $clog2(MAX_HAZ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW-1:0]   in_top,
    input  logic [CW-1:0]   in_left,
    input  logic [CW-1:0]   in_bottom,
    input  logic [CW-1:0]   in_right,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data,
    output logic            out_half,
    output logic            out_ovf,
    output logic [CNTW-1:0] hz_count
);

    // state     | meaning
    // S_LOAD    | accepting boxes into free slots
    // S_DRAIN   | slots full, swallowing beats until in_last (frame marked truncated)
    // S_ENCODE  | OR one stored box per cycle into the mask
    // S_SEND_LO | presenting cells 0-15
    // S_SEND_HI | presenting cells 16-31; handshake clears the frame
    typedef enum logic [2:0] {
        S_LOAD, S_DRAIN, S_ENCODE, S_SEND_LO, S_SEND_HI
    } state_t;

    localparam int NCELL = ROWS * COLS;
    localparam int BOXW  = 4 * CW;

    state_t              state_q, state_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NCELL-1:0]    mask_q, mask_d;
    logic                ovf_q, ovf_d;
    logic [BOXW-1:0]     slots_q [MAX_HAZ];
    logic [BOXW-1:0]     slots_d [MAX_HAZ];
    logic                in_hs;

    // Rasterise one box; coordinates past the grid edge clip, inverted boxes are empty.
    function automatic logic [NCELL-1:0] box_mask(input logic [BOXW-1:0] box);
        logic [CW-1:0] t, l, b, r;
        int r0, r1, c0, c1;
        box_mask = '0;
        {t, l, b, r} = box;
        r0 = int'(t >> ROW_SHIFT);
        r1 = int'(b >> ROW_SHIFT);
        c0 = int'(l >> COL_SHIFT);
        c1 = int'(r >> COL_SHIFT);
        if (r1 > ROWS - 1) r1 = ROWS - 1;
        if (c1 > COLS - 1) c1 = COLS - 1;
        if (t <= b && l <= r) begin
            for (int row = 0; row < ROWS; row++) begin
                for (int col = 0; col < COLS; col++) begin
                    if (row >= r0 && row <= r1 && col >= c0 && col <= c1)
                        box_mask[row*COLS+col] = 1'b1;
                end
            end
        end
    endfunction

    assign in_hs = in_valid && in_ready;

    // State and frame registers, synchronous reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            count_q <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
        end
    end

    // Box slot storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        slots_q <= slots_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: begin
                if (in_hs) begin
                    if (in_last)
                        state_d = S_ENCODE;
                    else if (count_q == CNTW'(MAX_HAZ - 1))
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN:   if (in_hs && in_last) state_d = S_ENCODE;
            S_ENCODE:  if ({1'b0, idx_q} == count_q - CNTW'(1)) state_d = S_SEND_LO;
            S_SEND_LO: if (out_ready) state_d = S_SEND_HI;
            S_SEND_HI: if (out_ready) state_d = S_LOAD;
            default:   state_d = S_LOAD;
        endcase
    end

    // Frame datapath: slot fill, mask accumulation, end-of-frame clear.
    always_comb begin
        slots_d = slots_q;
        count_d = count_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_LOAD: begin
                idx_d = '0;
                if (in_hs) begin
                    slots_d[count_q[IW-1:0]] = {in_top, in_left, in_bottom, in_right};
                    count_d = count_q + CNTW'(1);
                    if (!in_last && count_q == CNTW'(MAX_HAZ - 1))
                        ovf_d = 1'b1;
                end
            end
            S_ENCODE: begin
                mask_d = mask_q | box_mask(slots_q[idx_q]);
                idx_d  = idx_q + IW'(1);
            end
            S_SEND_HI: begin
                if (out_ready) begin
                    count_d = '0;
                    mask_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Stream outputs decoded from state; data is held by the frozen mask register.
    always_comb begin
        in_ready  = !rst && (state_q == S_LOAD || state_q == S_DRAIN);
        out_valid = 1'b0;
        out_data  = 16'h0000;
        out_half  = 1'b0;
        out_ovf   = 1'b0;
        hz_count  = count_q;
        if (state_q == S_SEND_LO) begin
            out_valid = 1'b1;
            out_data  = mask_q[15:0];
            out_ovf   = ovf_q;
        end else if (state_q == S_SEND_HI) begin
            out_valid = 1'b1;
            out_data  = mask_q[31:16];
            out_half  = 1'b1;
            out_ovf   = ovf_q;
        end
    end

endmodule

// File: tb/tb_hazard_frame_sequencer.sv
// Bench for hazard_frame_sequencer: expected halves are queued as each frame is
// driven and popped by a monitor on every output handshake.
module tb_hazard_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_top, in_left, in_bottom, in_right;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_half;
    logic        out_ovf;
    logic [4:0]  hz_count;

    hazard_frame_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_top(in_top), .in_left(in_left), .in_bottom(in_bottom), .in_right(in_right),
        .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_half(out_half), .out_ovf(out_ovf),
        .hz_count(hz_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        half;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [4:0]  t, l, b, r;
        logic [15:0] lo, hi;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic push_frame(input logic [15:0] lo, input logic [15:0] hi, input logic ovf);
        sb.push_back('{lo, 1'b0, ovf});
        sb.push_back('{hi, 1'b1, ovf});
    endtask

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic drive_beat(input logic [4:0] t, input logic [4:0] l,
                              input logic [4:0] b, input logic [4:0] r, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; in_top = t; in_left = l; in_bottom = b; in_right = r; in_last = last;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_handshake", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called just after the in_last handshake edge; counts edges from the handshake cycle.
    task automatic measure_lat(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every accepted half must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got data 0x%0h half %0d with nothing expected",
                         out_data, out_half);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e.data));
                check("out_half", 32'(out_half), 32'(mon_e.half));
                check("out_ovf",  32'(out_ovf),  32'(mon_e.ovf));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   lat;

        tbl[0] = '{5'd0, 5'd0,  5'd7,  5'd31, 16'hFFFF, 16'hFFFF};
        tbl[1] = '{5'd0, 5'd0,  5'd31, 5'd31, 16'hFFFF, 16'hFFFF};
        tbl[2] = '{5'd0, 5'd0,  5'd0,  5'd0,  16'h0001, 16'h0000};
        tbl[3] = '{5'd2, 5'd4,  5'd3,  5'd7,  16'h0200, 16'h0000};
        tbl[4] = '{5'd4, 5'd28, 5'd7,  5'd31, 16'h0000, 16'h8080};
        tbl[5] = '{5'd8, 5'd0,  5'd9,  5'd31, 16'h0000, 16'h0000};
        tbl[6] = '{5'd1, 5'd3,  5'd2,  5'd4,  16'h0303, 16'h0000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
        in_top = '0; in_left = '0; in_bottom = '0; in_right = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_outputs", 32'({out_valid, out_half, out_ovf, out_data, hz_count}), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Two-box frame: latency, hz_count and clear after the frame.
        out_ready = 1'b1;
        push_frame(16'h0001, 16'h6000, 1'b0);
        drive_beat(5'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        drive_beat(5'd6, 5'd23, 5'd7, 5'd25, 1'b1);
        check("in_ready_encode", 32'(in_ready), 32'd0);
        measure_lat(lat);
        check("latency_2box", 32'(lat), 32'd3);
        check("hz_count_2box", 32'(hz_count), 32'd2);
        wait_drain();
        check("hz_count_cleared", 32'(hz_count), 32'd0);

        // Single-box frames from the table.
        for (int k = 0; k < 7; k++) begin
            push_frame(tbl[k].lo, tbl[k].hi, 1'b0);
            drive_beat(tbl[k].t, tbl[k].l, tbl[k].b, tbl[k].r, 1'b1);
            wait_drain();
        end

        // Back-pressure in SEND_LO.
        out_ready = 1'b0;
        push_frame(16'h0001, 16'h0000, 1'b0);
        drive_beat(5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 32'({out_valid, out_half, in_ready, out_data}),
                  32'({1'b1, 1'b0, 1'b0, 16'h0001}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_send_hi", 32'({out_valid, out_half}), 32'b11);
        wait_drain();

        // Overflow: 16 stored, 2 drained, truncated flag on both halves.
        push_frame(16'hFFFF, 16'h0000, 1'b1);
        for (int i = 0; i < 16; i++) begin
            drive_beat(5'(2 * (i >> 3)), 5'(4 * (i & 7)), 5'(2 * (i >> 3)), 5'(4 * (i & 7)), 1'b0);
        end
        drive_beat(5'd6, 5'd0, 5'd6, 5'd0, 1'b0);
        drive_beat(5'd6, 5'd0, 5'd6, 5'd0, 1'b1);
        measure_lat(lat);
        check("latency_ovf", 32'(lat), 32'd17);
        check("hz_count_ovf", 32'(hz_count), 32'd16);
        wait_drain();

        // Inverted box still counts but contributes nothing.
        push_frame(16'h0002, 16'h0000, 1'b0);
        drive_beat(5'd5, 5'd0, 5'd2, 5'd3, 1'b0);
        drive_beat(5'd0, 5'd4, 5'd0, 5'd4, 1'b1);
        measure_lat(lat);
        check("latency_inv", 32'(lat), 32'd3);
        check("hz_count_inv", 32'(hz_count), 32'd2);
        wait_drain();

        // Reset during ENCODE aborts the frame without residue.
        drive_beat(5'd0, 5'd0, 5'd7, 5'd31, 1'b0);
        drive_beat(5'd0, 5'd0, 5'd7, 5'd31, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort_state", 32'({out_valid, in_ready, hz_count}), 32'({1'b0, 1'b1, 5'd0}));
        push_frame(16'h0001, 16'h0000, 1'b0);
        drive_beat(5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        wait_drain();
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_frame_sequencer.md
Name: hazard_frame_sequencer

Overview:
- Sequential front end for the hazard occupancy grid (4 rows x 8 cols, 32 cells).
- Accepts hazard bounding boxes one beat at a time over a valid/ready stream and stores up to MAX_HAZ per frame.
- Walks the stored boxes one per cycle to build the 32-bit cell mask.
- Emits the mask as two 16-bit beats (cells 0-15, then 16-31) over a valid/ready handshake to the spike-input stage.

Parameters:
MAX_HAZ, 16, hazard slots per frame (count register is clog2(MAX_HAZ)+1 bits)
CW, 5, coordinate width of top/left/bottom/right
ROWS, 4, grid rows
COLS, 8, grid columns
ROW_SHIFT, 1, row = y >> ROW_SHIFT
COL_SHIFT, 2, col = x >> COL_SHIFT

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  hazard beat valid
in_ready  out  1  sequencer accepts beat
in_top  in  CW  box top y (inclusive)
in_left  in  CW  box left x (inclusive)
in_bottom  in  CW  box bottom y (inclusive)
in_right  in  CW  box right x (inclusive)
in_last  in  1  final hazard of frame
out_valid  out  1  mask half valid
out_ready  in  1  consumer accepts half
out_data  out  16  mask half
out_half  out  1  0 = cells 0-15, 1 = cells 16-31
out_ovf  out  1  frame truncated (valid with both halves)
hz_count  out  clog2(MAX_HAZ)+1  hazards stored in current frame

Behaviour:
- Reset, on the clock edge with rst=1:
  - state=LOAD; count=0; mask=0; ovf=0.
  - out_valid=0, out_data=0, out_half=0, out_ovf=0, hz_count=0.
  - in_ready=0 while rst=1.
- Reset mid-frame, in any state, discards stored boxes and the partial mask. No half-frame is emitted after reset.
- Cell index = row*COLS + col. The mask is indexed by cell number.
- States:
  - LOAD:
    - in_ready=1.
    - On in_valid&in_ready, store the box in slot count, then count++.
    - in_last accepted -> ENCODE.
    - Slot MAX_HAZ-1 filled without in_last -> DRAIN, ovf=1.
  - DRAIN:
    - in_ready=1.
    - Beats are accepted and discarded.
    - in_last accepted -> ENCODE.
  - ENCODE:
    - in_ready=0.
    - idx steps 0..count-1, one box per cycle; mask |= box_mask(idx).
    - Takes exactly count cycles, then -> SEND_LO.
  - SEND_LO:
    - out_valid=1, out_data=mask[15:0], out_half=0, out_ovf=ovf.
    - out_valid&out_ready -> SEND_HI.
  - SEND_HI:
    - out_valid=1, out_data=mask[31:16], out_half=1, out_ovf=ovf.
    - Handshake -> LOAD; count, mask and ovf are cleared in the same edge.
- Every in_last beat carries a hazard, so count>=1 in ENCODE.
- box_mask rules:
  - r0 = top>>ROW_SHIFT, r1 = min(bottom>>ROW_SHIFT, ROWS-1).
  - c0 = left>>COL_SHIFT, c1 = min(right>>COL_SHIFT, COLS-1).
  - All cells with r0<=row<=r1 and c0<=col<=c1 are set.
  - top>bottom or left>right gives an empty mask; the box still counts toward count.
  - r0>=ROWS or c0>=COLS gives an empty mask.
- Handshakes:
  - out_data, out_half and out_ovf hold stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake, except on rst.
  - in_ready=0 in ENCODE/SEND_LO/SEND_HI. The upstream source must hold its beat.
- Latency from the in_last handshake to first out_valid = count+1 cycles:
  - 1 cycle for the LOAD->ENCODE transition.
  - count cycles in ENCODE.
- Throughput: minimum frame period = count (load) + 1 + count (encode) + 2 (send) cycles.
- hz_count reflects stored slots (saturates at MAX_HAZ). It is cleared with the frame.

Test Plan:
1. Frame with boxes (t0,l0,b1,r2), then (t6,l23,b7,r25,last); out_ready=1 -> SEND_LO out_data=0x0001, then out_half=1 out_data=0x6000 (cells 29,30); out_ovf=0; first out_valid 3 cycles after the in_last handshake; hz_count=2.
2. Single box (t0,l0,b7,r31,last) -> 0xFFFF, 0xFFFF. A box (t0,l0,b31,r31) clips to the same result.
3. Back-pressure: hold out_ready=0 for 5 cycles in SEND_LO -> out_valid=1, out_data=0x0001, out_half=0 stable and in_ready=0 throughout; after release, SEND_HI follows on the next cycle.
4. Overflow: 18 beats. Beat i<16 is (t=2*(i>>3), l=4*(i&7), b=t, r=l); beats 17-18 are (t6,l0,b6,r0), with last on beat 18 -> all 18 accepted, lo=0xFFFF, hi=0x0000, out_ovf=1 on both halves, ENCODE lasts 16 cycles.
5. Inverted box (t5,l0,b2,r3) plus (t0,l4,b0,r4,last) -> lo=0x0002, hi=0x0000, hz_count=2.
6. Assert rst for one cycle during ENCODE -> next cycle out_valid=0, in_ready=1, hz_count=0; a new frame (t0,l0,b0,r0,last) yields exactly lo=0x0001, hi=0x0000 with no residue from the aborted frame.
